counter_monitor: RTL and testbench

Passive protocol monitor and checker for the `counter` block's observation interface. It taps the same `enable`/`load`/`load_value` stimulus the counter receives and its `count`/`overflow` outputs, and runs a cycle-accurate reference model. It flags any divergence and accumulates event and error statistics. It is used in simulation benches and as a synthesizable on-chip self-check beside `counter`.

---
 rtl/counter_monitor.sv | 131 +++++++++++++
 tb/tb_counter_monitor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_monitor.sv
// Passive checker for the counter block: runs a cycle-accurate model of the
// counter beside it, flags divergence one cycle later and keeps saturating statistics.
module counter_monitor #(
  parameter int WIDTH  = 8,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic [WIDTH-1:0]  count,
  input  logic              overflow,
  input  logic              clear,
  output logic [WIDTH-1:0]  exp_count,
  output logic              mismatch,
  output logic              failed,
  output logic [STAT_W-1:0] error_count,
  output logic [STAT_W-1:0] overflow_events,
  output logic [STAT_W-1:0] load_events,
  output logic [WIDTH-1:0]  first_err_exp,
  output logic [WIDTH-1:0]  first_err_act
);

  typedef enum logic [1:0] {IDLE, CHECK, FAIL} state_e;

  localparam logic [WIDTH-1:0]  CNT_ONE  = 1;
  localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [STAT_W-1:0] STAT_ONE = 1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   exp_count_q, exp_count_d;
  logic               exp_ovf_q, exp_ovf_d;
  logic               mismatch_q, mismatch_d;
  logic [STAT_W-1:0]  error_count_q, error_count_d;
  logic [STAT_W-1:0]  ovf_events_q, ovf_events_d;
  logic [STAT_W-1:0]  load_events_q, load_events_d;
  logic               cap_valid_q, cap_valid_d;
  logic [WIDTH-1:0]   cap_exp_q, cap_exp_d;
  logic [WIDTH-1:0]   cap_act_q, cap_act_d;

  logic               diff;
  logic [WIDTH-1:0]   base;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == STAT_MAX) ? v : v + STAT_ONE;
  endfunction

  always_comb begin
    diff = (count != exp_count_q) || (overflow != exp_ovf_q);
    // Resync to the observed count so a single fault is logged only once.
    base = diff ? count : exp_count_q;

    exp_count_d   = base;
    exp_ovf_d     = 1'b0;
    mismatch_d    = diff;
    error_count_d = error_count_q;
    ovf_events_d  = ovf_events_q;
    load_events_d = load_events_q;
    cap_valid_d   = cap_valid_q;
    cap_exp_d     = cap_exp_q;
    cap_act_d     = cap_act_q;
    state_d       = state_q;

    if (load) begin
      exp_count_d = load_value;
    end else if (enable) begin
      exp_count_d = base + CNT_ONE;
      exp_ovf_d   = (base == CNT_MAX);
    end

    if (clear) begin
      error_count_d = '0;
      ovf_events_d  = '0;
      load_events_d = '0;
      cap_valid_d   = 1'b0;
      cap_exp_d     = '0;
      cap_act_d     = '0;
    end else begin
      if (diff)     error_count_d = sat_inc(error_count_q);
      if (overflow) ovf_events_d  = sat_inc(ovf_events_q);
      if (load)     load_events_d = sat_inc(load_events_q);
      if (diff && state_q == CHECK && !cap_valid_q) begin
        cap_valid_d = 1'b1;
        cap_exp_d   = exp_count_q;
        cap_act_d   = count;
      end
    end

    if (clear)                state_d = CHECK;
    else if (diff)            state_d = FAIL;
    else if (state_q == IDLE) state_d = CHECK;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      exp_count_q   <= '0;
      exp_ovf_q     <= 1'b0;
      mismatch_q    <= 1'b0;
      error_count_q <= '0;
      ovf_events_q  <= '0;
      load_events_q <= '0;
      cap_valid_q   <= 1'b0;
      cap_exp_q     <= '0;
      cap_act_q     <= '0;
    end else begin
      state_q       <= state_d;
      exp_count_q   <= exp_count_d;
      exp_ovf_q     <= exp_ovf_d;
      mismatch_q    <= mismatch_d;
      error_count_q <= error_count_d;
      ovf_events_q  <= ovf_events_d;
      load_events_q <= load_events_d;
      cap_valid_q   <= cap_valid_d;
      cap_exp_q     <= cap_exp_d;
      cap_act_q     <= cap_act_d;
    end
  end

  assign exp_count       = exp_count_q;
  assign mismatch        = mismatch_q;
  assign failed          = (state_q == FAIL);
  assign error_count     = error_count_q;
  assign overflow_events = ovf_events_q;
  assign load_events     = load_events_q;
  assign first_err_exp   = cap_exp_q;
  assign first_err_act   = cap_act_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: a behavioural counter feeds the monitor, faults are
// injected on purpose, and a high-level model predicts every monitor output.
module tb_counter_monitor;

  localparam int W   = 8;
  localparam int SW  = 6;
  localparam int MOD = 1 << W;
  localparam int SAT = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, enable, load, clear, overflow;
  logic [W-1:0]  load_value, count;
  logic [W-1:0]  exp_count, first_err_exp, first_err_act;
  logic          mismatch, failed;
  logic [SW-1:0] error_count, overflow_events, load_events;

  counter_monitor #(.WIDTH(W), .STAT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .load_value(load_value), .count(count), .overflow(overflow), .clear(clear),
    .exp_count(exp_count), .mismatch(mismatch), .failed(failed),
    .error_count(error_count), .overflow_events(overflow_events),
    .load_events(load_events), .first_err_exp(first_err_exp),
    .first_err_act(first_err_act)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_CHECK, M_FAIL} mstate_e;

  int checks = 0;
  int errors = 0;

  // Behaviour of the monitored counter; overwriting ctr models a corrupted register.
  int ctr = 0;
  int ctr_ovf = 0;
  bit inj_ovf = 0;

  // Expected monitor behaviour.
  mstate_e m_state = M_IDLE;
  int  m_exp = 0, m_ovf = 0, m_mm = 0;
  int  m_err = 0, m_ovfev = 0, m_ldev = 0;
  bit  m_cap_valid = 0;
  int  m_cap_exp = 0, m_cap_act = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    cmp("exp_count", 32'(exp_count), m_exp);
    cmp("mismatch", 32'(mismatch), m_mm);
    cmp("failed", 32'(failed), (m_state == M_FAIL) ? 1 : 0);
    cmp("error_count", 32'(error_count), m_err);
    cmp("overflow_events", 32'(overflow_events), m_ovfev);
    cmp("load_events", 32'(load_events), m_ldev);
    cmp("first_err_exp", 32'(first_err_exp), m_cap_exp);
    cmp("first_err_act", 32'(first_err_act), m_cap_act);
  endtask

  function automatic int sat(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // Drive one cycle of stimulus, predict its effect, then check after the edge.
  task automatic applyStimulus(input bit rst, input bit en, input bit ld, input int lv, input bit clr);
    int obs_cnt, obs_ovf, base;
    bit mm;
    rst_n      = rst;
    enable     = en;
    load       = ld;
    load_value = W'(lv);
    clear      = clr;
    obs_cnt    = ctr % MOD;
    obs_ovf    = ctr_ovf ^ int'(inj_ovf);
    count      = W'(obs_cnt);
    overflow   = obs_ovf[0];
    if (!rst) begin
      ctr = 0; ctr_ovf = 0;
      m_state = M_IDLE;
      m_exp = 0; m_ovf = 0; m_mm = 0;
      m_err = 0; m_ovfev = 0; m_ldev = 0;
      m_cap_valid = 0; m_cap_exp = 0; m_cap_act = 0;
    end else begin
      mm   = (obs_cnt != m_exp) || (obs_ovf != m_ovf);
      base = mm ? obs_cnt : m_exp;
      if (clr) begin
        m_err = 0; m_ovfev = 0; m_ldev = 0;
        m_cap_valid = 0; m_cap_exp = 0; m_cap_act = 0;
      end else begin
        if (mm)      m_err   = sat(m_err);
        if (obs_ovf) m_ovfev = sat(m_ovfev);
        if (ld)      m_ldev  = sat(m_ldev);
        if (mm && m_state == M_CHECK && !m_cap_valid) begin
          m_cap_valid = 1; m_cap_exp = m_exp; m_cap_act = obs_cnt;
        end
      end
      if (clr)     m_state = M_CHECK;
      else if (mm) m_state = M_FAIL;
      else if (m_state == M_IDLE) m_state = M_CHECK;
      m_mm  = mm;
      m_ovf = (!ld && en && base == MOD - 1) ? 1 : 0;
      m_exp = ld ? lv : (en ? (base + 1) % MOD : base);
      ctr_ovf = (!ld && en && obs_cnt == MOD - 1) ? 1 : 0;
      ctr     = ld ? lv : (en ? (obs_cnt + 1) % MOD : obs_cnt);
    end
    inj_ovf = 0;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst_n = 0; enable = 0; load = 0; load_value = '0; clear = 0;
    count = '0; overflow = 0;
    @(negedge clk);

    // Reset, then count up 20 cycles.
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 99, 1);
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, 0, 0);
    cmp("plan_count20", 32'(exp_count), 20);

    // Load 250 and count through the wrap.
    applyStimulus(1, 0, 1, 250, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    cmp("plan_ovf_events", 32'(overflow_events), 1);
    cmp("plan_load_events", 32'(load_events), 1);
    cmp("plan_no_errors", 32'(error_count), 0);

    // Single fault: 7 observed where 5 expected.
    applyStimulus(1, 0, 1, 3, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    ctr = 7;
    applyStimulus(1, 1, 0, 0, 0);
    cmp("plan_fault_mm", 32'(mismatch), 1);
    cmp("plan_fault_cap_exp", 32'(first_err_exp), 5);
    cmp("plan_fault_cap_act", 32'(first_err_act), 7);
    cmp("plan_fault_resync", 32'(exp_count), 8);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0);
    cmp("plan_fault_once", 32'(error_count), 1);

    // Second fault, then clear.
    ctr = ctr + 2;
    applyStimulus(1, 1, 0, 0, 0);
    cmp("plan_two_errors", 32'(error_count), 2);
    cmp("plan_cap_kept", 32'(first_err_act), 7);
    applyStimulus(1, 1, 0, 0, 1);
    cmp("plan_clear_failed", 32'(failed), 0);
    cmp("plan_clear_errors", 32'(error_count), 0);

    // Load beats enable at all-ones; a spurious overflow is flagged.
    applyStimulus(1, 0, 1, 255, 0);
    applyStimulus(1, 1, 1, 255, 0);
    cmp("plan_load_wins", 32'(exp_count), 255);
    inj_ovf = 1;
    applyStimulus(1, 0, 0, 0, 0);
    cmp("plan_spurious_ovf", 32'(mismatch), 1);

    // Clear and a fault on the same edge.
    ctr = ctr + 1;
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0);

    // Reset mid-run after errors.
    ctr = ctr + 5;
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    cmp("plan_reset_errors", 32'(error_count), 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 0);
    cmp("plan_resume", 32'(exp_count), 5);

    // Randomized traffic with occasional faults, clears and resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) ctr = int'($urandom_range(0, MOD - 1));
      if ($urandom_range(0, 25) == 0) inj_ovf = 1;
      applyStimulus($urandom_range(0, 60) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 9) == 0, int'($urandom_range(0, MOD - 1)),
                    $urandom_range(0, 40) == 0);
    end

    // Saturation of every statistic.
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 0; i < SAT + 6; i++) begin
      inj_ovf = 1;
      applyStimulus(1, 0, 1, 251, 0);
    end
    cmp("sat_errors", 32'(error_count), SAT);
    cmp("sat_ovf_events", 32'(overflow_events), SAT);
    cmp("sat_load_events", 32'(load_events), SAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
